// File: rtl/conv1d_feeder.sv
// conv1d_feeder: front end for the conv1d dot-product datapath.
// Loads a rows-tap kernel serially, keeps a sliding window of the last rows
// samples from a valid/ready stream, flags each new full window, and tracks
// conv1d's fixed pipeline latency so the consumer knows when conv1d.out is valid.
module conv1d_feeder #(
    parameter int bw   = 8,
    parameter int rows = 8,
    parameter int lat  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 kern_wr,
    input  logic [bw-1:0]        kern_din,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 s_valid,
    input  logic [bw-1:0]        s_data,
    output logic                 s_ready,
    output logic [rows*bw-1:0]   A,
    output logic [rows*bw-1:0]   kern,
    output logic                 win_valid,
    output logic                 res_valid,
    output logic                 kern_rdy,
    output logic [1:0]           state,
    output logic [15:0]          res_count
);

    // Counter width able to hold the value rows (tap count and fill count).
    localparam int              CW   = $clog2(rows + 1);
    localparam logic [CW-1:0]   FULL = CW'(rows);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Registered state
    state_t               r_state;
    logic [rows*bw-1:0]   r_A;
    logic [rows*bw-1:0]   r_kern;
    logic [CW-1:0]        r_tap_cnt;
    logic [CW-1:0]        r_fill_cnt;
    logic                 r_win_valid;
    logic [lat-1:0]       r_vpipe;
    logic [15:0]          r_res_count;

    // Combinational helpers
    state_t               w_state_nxt;
    logic                 w_s_ready;
    logic                 w_accept;
    logic                 w_kern_rdy;
    logic                 w_start_ok;
    logic                 w_kern_wr_ok;
    logic [CW-1:0]        w_fill_nxt;
    logic                 w_win_nxt;
    logic                 w_pipe_busy;
    logic                 w_res_valid;

    // Handshake and qualification terms. s_ready depends only on the state
    // register so it never forms a loop with the accept-driven logic below.
    assign w_s_ready    = (r_state == ST_FILL) || (r_state == ST_RUN);
    assign w_accept     = s_valid && w_s_ready;
    assign w_kern_rdy   = (r_tap_cnt == FULL);
    assign w_start_ok   = (r_state == ST_IDLE) && start && w_kern_rdy;
    // An honoured start takes priority over a kernel write in the same cycle.
    assign w_kern_wr_ok = (r_state == ST_IDLE) && kern_wr && !w_start_ok;
    assign w_pipe_busy  = r_win_valid || (|r_vpipe);
    assign w_res_valid  = r_vpipe[lat-1];

    // Next fill count: cleared on start, saturating increment per accept.
    always_comb begin
        w_fill_nxt = r_fill_cnt;
        if (w_start_ok) begin
            w_fill_nxt = '0;
        end else if (w_accept && (r_fill_cnt != FULL)) begin
            w_fill_nxt = r_fill_cnt + 1'b1;
        end
    end

    // A new full window is on A the cycle after an accept that leaves it full.
    assign w_win_nxt = w_accept && (w_fill_nxt == FULL);

    // Next-state logic for the streaming controller.
    // NOTE: always_comb assigns its output a default first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                if (stop) begin
                    w_state_nxt = ST_DRAIN;
                end else if (w_accept && (w_fill_nxt == FULL)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave only once every window in flight has produced its result.
                if (!w_pipe_busy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    // NOTE: sequential blocks use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Kernel shift register and saturating tap counter; only rst clears them.
    // NOTE: the window and kernel registers are reset too, because a reset must
    // leave A and kern at zero rather than holding stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kern    <= '0;
            r_tap_cnt <= '0;
        end else if (w_kern_wr_ok) begin
            r_kern <= {kern_din, r_kern[rows*bw-1:bw]};
            if (r_tap_cnt != FULL) begin
                r_tap_cnt <= r_tap_cnt + 1'b1;
            end
        end
    end

    // Sample window: newest sample enters at the top slot, oldest drops off slot 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_A <= '0;
        end else if (w_start_ok) begin
            r_A <= '0;
        end else if (w_accept) begin
            r_A <= {s_data, r_A[rows*bw-1:bw]};
        end
    end

    // Fill counter and window-valid strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fill_cnt  <= '0;
            r_win_valid <= 1'b0;
        end else begin
            r_fill_cnt  <= w_fill_nxt;
            r_win_valid <= w_win_nxt;
        end
    end

    // Latency tracker: win_valid delayed by the conv1d pipeline depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vpipe <= '0;
        end else begin
            r_vpipe <= (r_vpipe << 1) | lat'(r_win_valid);
        end
    end

    // Result counter: cleared on each honoured start, wraps at 2^16.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_count <= '0;
        end else if (w_start_ok) begin
            r_res_count <= '0;
        end else if (w_res_valid) begin
            r_res_count <= r_res_count + 16'd1;
        end
    end

    assign s_ready   = w_s_ready;
    assign A         = r_A;
    assign kern      = r_kern;
    assign win_valid = r_win_valid;
    assign res_valid = w_res_valid;
    assign kern_rdy  = w_kern_rdy;
    assign state     = r_state;
    assign res_count = r_res_count;

endmodule
